stream_pool_unit: RTL and testbench

Streaming successor to the array-based pooling block. Accepts one raster-scan pixel per beat, with all CH_IN channels packed. Applies zero padding internally and performs non-overlapping POOL_SIZE x POOL_SIZE max or average pooling. Emits one pooled pixel per beat over valid/ready handshakes. It sits between convolution stages of the CNN datapath and replaces whole-frame array ports with line-rate buffering.

---
 rtl/stream_pool_unit.sv | 122 ++++++++++++
 tb/tb_stream_pool_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pool_unit.sv
// Streaming zero-padded max/average pooler: one raster-scan pixel in per beat,
// one pooled pixel out, using a single row of window accumulators.
module stream_pool_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_SIZE   = 4,
  parameter int POOL_SIZE  = 2,
  parameter int CH_IN      = 3,
  parameter int PADDING    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH_IN*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH_IN*DATA_WIDTH-1:0] out_data,
  output logic                        out_last
);

  localparam int PW       = IMG_SIZE + 2*PADDING;
  localparam int OUT_SIZE = (PW - POOL_SIZE)/POOL_SIZE + 1;
  localparam int LOGP     = $clog2(POOL_SIZE);
  localparam int ACC_W    = DATA_WIDTH + 2*LOGP;
  localparam int SH       = 2*LOGP;
  localparam int CW       = $clog2(PW + 1);
  localparam int OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [CW-1:0] PAD_LO   = CW'(PADDING);
  localparam logic [CW-1:0] PAD_HI   = CW'(PADDING + IMG_SIZE);
  localparam logic [CW-1:0] OUT_LIM  = CW'(OUT_SIZE*POOL_SIZE);
  localparam logic [CW-1:0] LAST_POS = CW'(PW - 1);
  localparam logic [CW-1:0] PMASK    = CW'(POOL_SIZE - 1);
  localparam logic [OW-1:0] LAST_WIN = OW'(OUT_SIZE - 1);

  logic [CW-1:0]    row, col;
  logic             mode_q;
  logic [ACC_W-1:0] acc [OUT_SIZE][CH_IN];

  logic                        real_pos, in_win, first, completing, stall, advance;
  logic                        mode_eff, is_last, at_origin;
  logic [OW-1:0]               win_col, win_row;
  logic [ACC_W-1:0]            upd [CH_IN];
  logic [CH_IN*DATA_WIDTH-1:0] res;

  always_comb begin
    at_origin  = (row == '0) && (col == '0);
    real_pos   = (row >= PAD_LO) && (row < PAD_HI) && (col >= PAD_LO) && (col < PAD_HI);
    in_win     = (row < OUT_LIM) && (col < OUT_LIM);
    first      = in_win && ((row & PMASK) == '0) && ((col & PMASK) == '0);
    completing = in_win && ((row & PMASK) == PMASK) && ((col & PMASK) == PMASK);
    // Only a completing position needs the output register, so only it can stall.
    stall      = completing && out_valid && !out_ready;
    in_ready   = real_pos && !stall && !rst;
    advance    = real_pos ? (in_valid && in_ready) : !stall;
    win_col    = in_win ? OW'(col >> LOGP) : '0;
    win_row    = OW'(row >> LOGP);
    is_last    = (win_row == LAST_WIN) && (win_col == LAST_WIN);
    // The frame's first position must already pool with the newly sampled mode.
    mode_eff   = at_origin ? mode : mode_q;
  end

  always_comb begin
    logic [ACC_W-1:0] sample, prev;
    res    = '0;
    sample = '0;
    prev   = '0;
    for (int ch = 0; ch < CH_IN; ch++) begin
      upd[ch] = '0;
    end
    for (int ch = 0; ch < CH_IN; ch++) begin
      sample = real_pos ? ACC_W'(in_data[ch*DATA_WIDTH +: DATA_WIDTH]) : '0;
      prev   = acc[win_col][ch];
      if (first)         upd[ch] = sample;
      else if (mode_eff) upd[ch] = prev + sample;
      else               upd[ch] = (sample > prev) ? sample : prev;
      res[ch*DATA_WIDTH +: DATA_WIDTH] = mode_eff ? DATA_WIDTH'(upd[ch] >> SH)
                                                  : DATA_WIDTH'(upd[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int w = 0; w < OUT_SIZE; w++) begin
        for (int ch = 0; ch < CH_IN; ch++) begin
          acc[w][ch] <= '0;
        end
      end
    end else begin
      if (advance) begin
        if (at_origin) mode_q <= mode;
        if (col == LAST_POS) begin
          col <= '0;
          row <= (row == LAST_POS) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_win) begin
          for (int ch = 0; ch < CH_IN; ch++) begin
            acc[win_col][ch] <= upd[ch];
          end
        end
      end
      if (advance && completing) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_pool_unit.sv
// Directed bench for stream_pool_unit: a reference pooling model fills a
// scoreboard per frame, and a monitor pops and compares every accepted output.
module tb_stream_pool_unit;
  localparam int DW   = 8;
  localparam int CH   = 3;
  localparam int IMG  = 4;
  localparam int P    = 2;
  localparam int PAD  = 1;
  localparam int PW   = IMG + 2*PAD;
  localparam int OUT  = (PW - P)/P + 1;
  localparam int PIXW = CH*DW;
  localparam int NPIX = IMG*IMG;

  logic            clk = 1'b0;
  logic            rst, mode, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [PIXW-1:0] in_data, out_data;

  stream_pool_unit #(.DATA_WIDTH(DW), .IMG_SIZE(IMG), .POOL_SIZE(P), .CH_IN(CH), .PADDING(PAD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  logic [PIXW-1:0] frame_a [NPIX];
  logic [PIXW-1:0] frame_b [NPIX];
  logic [PIXW:0]   sb [$];
  logic [PIXW:0]   mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pooling over the zero-padded frame; pushes the first `count` outputs.
  task automatic push_frame(input bit use_b, input bit m, input int count);
    int n, acc, v, pr, pc;
    logic [PIXW-1:0] px, res;
    n = 0;
    for (int oi = 0; oi < OUT; oi++) begin
      for (int oj = 0; oj < OUT; oj++) begin
        res = '0;
        for (int ch = 0; ch < CH; ch++) begin
          acc = 0;
          for (int dr = 0; dr < P; dr++) begin
            for (int dc = 0; dc < P; dc++) begin
              pr = oi*P + dr;
              pc = oj*P + dc;
              v  = 0;
              if (pr >= PAD && pr < PAD+IMG && pc >= PAD && pc < PAD+IMG) begin
                px = use_b ? frame_b[(pr-PAD)*IMG + pc-PAD] : frame_a[(pr-PAD)*IMG + pc-PAD];
                v  = int'(px[ch*DW +: DW]);
              end
              if (m) acc += v;
              else if (v > acc) acc = v;
            end
          end
          if (m) acc = acc / (P*P);
          res[ch*DW +: DW] = DW'(acc);
        end
        if (n < count) sb.push_back({(oi == OUT-1 && oj == OUT-1), res});
        n++;
      end
    end
  endtask

  task automatic send_pixel(input logic [PIXW-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
  endtask

  task automatic send_frame(input bit use_b, input int from, input int upto);
    for (int k = from; k < upto; k++) send_pixel(use_b ? frame_b[k] : frame_a[k]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      chk("out_expected", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e[PIXW-1:0]));
        chk("out_last", 32'(out_last), 32'(mon_e[PIXW]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c7, c8;
    logic [PIXW:0] head;
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < NPIX; k++) begin
      frame_a[k] = {8'd0, 8'd0, 8'(k + 1)};
      frame_b[k] = {8'd255, 8'(16 - k), 8'(k + 1)};
    end
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: max mode
    push_frame(0, 0, 9);
    send_frame(0, 0, NPIX);
    mode = 1'b1;
    in_valid = 1'b0;
    wait_drain();

    // Frame 2: average mode, same data
    push_frame(0, 1, 9);
    send_frame(0, 0, NPIX);
    mode = 1'b0;
    in_valid = 1'b0;
    wait_drain();

    // Frame 3: all channels distinct
    push_frame(1, 0, 9);
    send_frame(1, 0, NPIX);
    in_valid = 1'b0;
    wait_drain();

    // Frame 4: backpressure holds the first output and stalls the next completion
    push_frame(0, 0, 9);
    out_ready = 1'b0;
    send_frame(0, 0, 2);
    in_data  = frame_a[2];
    in_valid = 1'b1;
    head = sb[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  32'(out_data),  32'(head[PIXW-1:0]));
    end
    out_ready = 1'b1;
    send_frame(0, 2, NPIX);
    in_valid = 1'b0;
    wait_drain();

    // Frame 5: partial frame, then reset
    push_frame(0, 0, 3);
    send_frame(0, 0, 7);
    in_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);

    // Frame 6: full frame after reset matches frame 1
    push_frame(0, 0, 9);
    send_frame(0, 0, NPIX);
    in_valid = 1'b0;
    wait_drain();

    // Frames 7/8: mode flips mid-frame, then back-to-back frames
    push_frame(0, 0, 9);
    send_frame(0, 0, 1);
    c7 = hs_cyc;
    send_frame(0, 1, 8);
    mode = 1'b1;
    send_frame(0, 8, NPIX);
    push_frame(1, 1, 9);
    send_frame(1, 0, 1);
    c8 = hs_cyc;
    send_frame(1, 1, NPIX);
    in_valid = 1'b0;
    wait_drain();
    chk("frame_period", 32'(c8 - c7), 32'(PW*PW));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
